// File: rtl/wb_wait_slave_pkg.sv
// Shared types and defaults for the wait-state Wishbone register slave.
// Holds the FSM encoding, counter widths and default parameter values.
package wb_wait_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_TERM = 2'd2
  } state_t;

  localparam int WAIT_CNT_W = 4;
  localparam int XFER_CNT_W = 16;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DEPTH  = 12;
  localparam int DEF_WAIT   = 0;

endpackage

// File: rtl/wb_regbank.sv
// Register array with per-byte write enables and a combinational read port.
// Writes land on the clock edge; out-of-range reads return zero.
module wb_regbank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 12,
  parameter int ADDR_W = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_adr,
  input  logic [DATA_W-1:0]   wr_dat,
  input  logic [DATA_W/8-1:0] wr_sel,
  input  logic [ADDR_W-1:0]   rd_adr,
  output logic [DATA_W-1:0]   rd_dat
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              rd_in_range;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_sel[b]) begin
          mem[wr_adr][b*8 +: 8] <= wr_dat[b*8 +: 8];
        end
      end
    end
  end

  assign rd_in_range = ({1'b0, rd_adr} < (ADDR_W+1)'(DEPTH));
  assign rd_dat      = rd_in_range ? mem[rd_adr] : '0;

endmodule

// File: rtl/wb_wait_slave.sv
// Wishbone classic slave: WAIT wait states, then a one-cycle ack (in range) or err.
// Termination WAIT+1 cycles after the request is sampled; dropping cyc/stb while waiting aborts.
module wb_wait_slave
  import wb_wait_slave_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WAIT   = DEF_WAIT
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [ADDR_W-1:0]     wb_adr,
  input  logic [DATA_W-1:0]     wb_dat_w,
  input  logic [DATA_W/8-1:0]   wb_sel,
  output logic [DATA_W-1:0]     wb_dat_r,
  output logic                  wb_ack,
  output logic                  wb_err,
  output logic [XFER_CNT_W-1:0] xfer_cnt
);

  state_t                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wcnt_q, wcnt_d;
  logic                    term_err_q;
  logic                    term_rd_q;
  logic [ADDR_W-1:0]       term_adr_q;
  logic [XFER_CNT_W-1:0]   xfer_cnt_q;

  logic                    req;
  logic                    in_range;
  logic                    enter_term;
  logic                    wr_en;
  logic [DATA_W-1:0]       rd_dat;

  assign req      = wb_cyc & wb_stb;
  assign in_range = ({1'b0, wb_adr} < (ADDR_W+1)'(DEPTH));

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    enter_term = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT == 0) begin
            state_d    = ST_TERM;
            enter_term = 1'b1;
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = WAIT_CNT_W'(WAIT - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == '0) begin
          state_d    = ST_TERM;
          enter_term = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      ST_TERM: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // Address, direction and data are taken from the edge that enters TERM.
  assign wr_en = enter_term & wb_we & in_range;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= '0;
      term_err_q <= 1'b0;
      term_rd_q  <= 1'b0;
      term_adr_q <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (enter_term) begin
        term_err_q <= ~in_range;
        term_rd_q  <= ~wb_we & in_range;
        term_adr_q <= wb_adr;
      end
      if (state_q == ST_TERM) begin
        xfer_cnt_q <= xfer_cnt_q + 1'b1;
      end
    end
  end

  wb_regbank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_regbank (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wr_en   (wr_en),
    .wr_adr  (wb_adr),
    .wr_dat  (wb_dat_w),
    .wr_sel  (wb_sel),
    .rd_adr  (term_adr_q),
    .rd_dat  (rd_dat)
  );

  assign wb_ack   = (state_q == ST_TERM) & ~term_err_q;
  assign wb_err   = (state_q == ST_TERM) &  term_err_q;
  assign wb_dat_r = ((state_q == ST_TERM) && term_rd_q) ? rd_dat : '0;
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_wb_wait_slave.sv
// Scoreboard bench for wb_wait_slave: one instance with WAIT=0, one with WAIT=3.
// Drivers queue hand-computed terminations; a negedge monitor pops and compares them.
module tb_wb_wait_slave;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 12;

  typedef struct {
    int          due;
    logic        ack;
    logic        err;
    logic [31:0] dat;
    logic [15:0] cnt;
  } exp_t;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic          rst   [2];
  logic          cyc   [2];
  logic          stb   [2];
  logic          we    [2];
  logic [AW-1:0] adr   [2];
  logic [DW-1:0] dat_w [2];
  logic [3:0]    sel   [2];
  logic [DW-1:0] dat_r [2];
  logic          ack   [2];
  logic          err   [2];
  logic [15:0]   xcnt  [2];

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] mcnt [2];
  int          cyc_n  = 0;
  int          n_chk  = 0;
  int          n_pass = 0;

  wb_wait_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT(0)) dut0 (
    .sys_clk(sys_clk), .sys_rst(rst[0]), .wb_cyc(cyc[0]), .wb_stb(stb[0]),
    .wb_we(we[0]), .wb_adr(adr[0]), .wb_dat_w(dat_w[0]), .wb_sel(sel[0]),
    .wb_dat_r(dat_r[0]), .wb_ack(ack[0]), .wb_err(err[0]), .xfer_cnt(xcnt[0])
  );

  wb_wait_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT(3)) dut3 (
    .sys_clk(sys_clk), .sys_rst(rst[1]), .wb_cyc(cyc[1]), .wb_stb(stb[1]),
    .wb_we(we[1]), .wb_adr(adr[1]), .wb_dat_w(dat_w[1]), .wb_sel(sel[1]),
    .wb_dat_r(dat_r[1]), .wb_ack(ack[1]), .wb_err(err[1]), .xfer_cnt(xcnt[1])
  );

  always @(posedge sys_clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  // Monitor: every termination must match the oldest queued expectation.
  always @(negedge sys_clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (ack[d] || err[d]) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          n_chk++;
          $display("FAIL unexpected_term dut%0d: ack=%0b err=%0b, want no termination (cycle %0d)",
                   d, ack[d], err[d], cyc_n);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("term_cycle_dut%0d", d), cyc_n, e.due);
          check($sformatf("ack_dut%0d", d), 32'(ack[d]), 32'(e.ack));
          check($sformatf("err_dut%0d", d), 32'(err[d]), 32'(e.err));
          check($sformatf("dat_r_dut%0d", d), dat_r[d], e.dat);
          check($sformatf("cnt_in_term_dut%0d", d), 32'(xcnt[d]), 32'(e.cnt));
        end
      end else begin
        check($sformatf("dat_r_idle_dut%0d", d), dat_r[d], 32'h0);
      end
    end
  end

  // Called just after a negedge; returns just after a negedge.
  task automatic xfer(input int d, input logic w, input logic [3:0] a, input logic [31:0] v,
                      input logic [3:0] s, input logic [31:0] exp_dat, input bit hold);
    exp_t e;
    int   k;
    int   n;
    bit   inr;
    inr   = (int'(a) < DEPTH);
    k     = stb[d] ? cyc_n + 1 : cyc_n;
    e.due = k + ((d == 1) ? 3 : 0) + 1;
    e.ack = inr;
    e.err = !inr;
    e.dat = (!w && inr) ? exp_dat : 32'h0;
    e.cnt = mcnt[d];
    mcnt[d] = mcnt[d] + 16'd1;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dat_w[d] = v; sel[d] = s;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!(ack[d] || err[d]) && n < 40);
    if (!(ack[d] || err[d])) begin
      n_chk++;
      $display("FAIL term_timeout dut%0d: no termination after %0d cycles, want one", d, n);
      if (d == 0) q0.delete();
      else        q1.delete();
    end
    if (!hold) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      @(negedge sys_clk);
    end
  endtask

  task automatic wr(input int d, input logic [3:0] a, input logic [31:0] v, input logic [3:0] s,
                    input bit hold);
    xfer(d, 1'b1, a, v, s, 32'h0, hold);
  endtask

  task automatic rd(input int d, input logic [3:0] a, input logic [31:0] exp_dat, input bit hold);
    xfer(d, 1'b0, a, 32'h0, 4'h0, exp_dat, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      adr[d] = '0; dat_w[d] = '0; sel[d] = '0; mcnt[d] = 16'h0;
    end
    repeat (3) @(negedge sys_clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ack_dut%0d", d), 32'(ack[d]), 32'h0);
      check($sformatf("rst_err_dut%0d", d), 32'(err[d]), 32'h0);
      check($sformatf("rst_xfer_cnt_dut%0d", d), 32'(xcnt[d]), 32'h0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge sys_clk);

    // WAIT=0: write then read back, one cycle to ack each.
    wr(0, 4'd2, 32'hA5A5_1234, 4'hF, 1'b0);
    rd(0, 4'd2, 32'hA5A5_1234, 1'b0);
    check("xfer_cnt_after_wr_rd", 32'(xcnt[0]), 32'd2);

    // Byte enables and an all-zero select.
    wr(0, 4'd1, 32'h1122_3344, 4'hF, 1'b0);
    wr(0, 4'd1, 32'hFFFF_FFFF, 4'h5, 1'b0);
    rd(0, 4'd1, 32'h11FF_33FF, 1'b0);
    wr(0, 4'd1, 32'h0000_0000, 4'h0, 1'b0);
    rd(0, 4'd1, 32'h11FF_33FF, 1'b0);

    // Out of range terminates with err and leaves storage alone.
    wr(0, 4'd13, 32'hDEAD_BEEF, 4'hF, 1'b0);
    rd(0, 4'd13, 32'h0, 1'b0);
    rd(0, 4'd2, 32'hA5A5_1234, 1'b0);
    rd(0, 4'd1, 32'h11FF_33FF, 1'b0);
    wr(0, 4'd11, 32'h0BAD_F00D, 4'hF, 1'b0);
    rd(0, 4'd11, 32'h0BAD_F00D, 1'b0);
    wr(0, 4'd12, 32'hFFFF_FFFF, 4'hF, 1'b0);
    rd(0, 4'd12, 32'h0, 1'b0);
    rd(0, 4'd0, 32'h0, 1'b0);
    check("xfer_cnt_dut0", 32'(xcnt[0]), 32'(mcnt[0]));

    // Counter wrap: seed just below the top, then two transfers.
    force dut0.xfer_cnt_q = 16'hFFFE;
    @(negedge sys_clk);
    release dut0.xfer_cnt_q;
    mcnt[0] = 16'hFFFE;
    rd(0, 4'd2, 32'hA5A5_1234, 1'b0);
    wr(0, 4'd0, 32'h0000_0001, 4'h1, 1'b0);
    check("xfer_cnt_wrap", 32'(xcnt[0]), 32'h0);

    // WAIT=3: single read, then three back-to-back with cyc/stb held.
    rd(1, 4'd0, 32'h0, 1'b0);
    wr(1, 4'd3, 32'h0102_0304, 4'hF, 1'b1);
    rd(1, 4'd3, 32'h0102_0304, 1'b1);
    rd(1, 4'd0, 32'h0, 1'b0);

    // Abort: strobe dropped after two wait cycles.
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 4'd4; dat_w[1] = 32'hCAFE_F00D; sel[1] = 4'hF;
    repeat (2) @(negedge sys_clk);
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    repeat (8) @(negedge sys_clk);
    check("xfer_cnt_after_abort", 32'(xcnt[1]), 32'(mcnt[1]));
    rd(1, 4'd4, 32'h0, 1'b0);

    // Reset in the middle of a wait: request is dropped, storage cleared.
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 4'd3;
    repeat (2) @(negedge sys_clk);
    rst[1] = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge sys_clk);
    check("midrst_ack", 32'(ack[1]), 32'h0);
    check("midrst_err", 32'(err[1]), 32'h0);
    check("midrst_dat_r", dat_r[1], 32'h0);
    check("midrst_xfer_cnt", 32'(xcnt[1]), 32'h0);
    rst[1] = 1'b0;
    mcnt[1] = 16'h0;
    repeat (6) @(negedge sys_clk);
    rd(1, 4'd3, 32'h0, 1'b0);
    wr(1, 4'd5, 32'h5555_AAAA, 4'hF, 1'b0);
    rd(1, 4'd5, 32'h5555_AAAA, 1'b0);
    check("xfer_cnt_after_rst", 32'(xcnt[1]), 32'd3);

    repeat (4) @(negedge sys_clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      n_chk++;
      $display("FAIL pending_terms: %0d/%0d expectations left, want 0/0", q0.size(), q1.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_wait_slave.md
WB_WAIT_SLAVE -- requirements
Module: wb_wait_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 4, word-address width.
REQ-003 SHALL have parameter DEPTH, default 12, number of implemented registers (1..2^ADDR_W).
REQ-004 SHALL have parameter WAIT, default 0, wait states inserted before termination (0..15).
REQ-005 SHALL have port sys_clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port sys_rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port wb_cyc  in  1  bus cycle valid.
REQ-008 SHALL have port wb_stb  in  1  strobe.
REQ-009 SHALL have port wb_we  in  1  1 = write, 0 = read.
REQ-010 SHALL have port wb_adr  in  ADDR_W  word address.
REQ-011 SHALL have port wb_dat_w  in  DATA_W  write data.
REQ-012 SHALL have port wb_sel  in  DATA_W/8  byte enables.
REQ-013 SHALL have port wb_dat_r  out  DATA_W  read data, valid while wb_ack high.
REQ-014 SHALL have port wb_ack  out  1  normal termination, one-cycle pulse.
REQ-015 SHALL have port wb_err  out  1  error termination, one-cycle pulse.
REQ-016 SHALL have port xfer_cnt  out  16  count of completed ack/err terminations.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, TERM; reset state IDLE.
REQ-018 IDLE: on sampled wb_cyc & wb_stb SHALL go to TERM if WAIT==0, else to WAIT with wait counter loaded to WAIT-1.
REQ-019 WAIT: SHALL decrement counter each cycle; at counter 0 with cyc & stb still high SHALL go to TERM.
REQ-020 WAIT: if wb_cyc or wb_stb low in any cycle SHALL abort to IDLE; no write, no termination, no count change.
REQ-021 TERM: exactly one of wb_ack/wb_err SHALL be high for exactly one cycle; next state always IDLE, regardless of inputs.
REQ-022 Termination latency SHALL be WAIT+1 cycles after the first IDLE cycle sampling cyc & stb; back-to-back requests SHALL take WAIT+2 cycles each (one IDLE cycle between terminations).
REQ-023 wb_adr < DEPTH: SHALL terminate with wb_ack; wb_adr >= DEPTH: SHALL terminate with wb_err.
REQ-024 Write with ack SHALL update each byte i of register wb_adr where wb_sel[i]=1, on the edge entering TERM, using inputs sampled at that edge.
REQ-025 Read with ack SHALL present register wb_adr on wb_dat_r during TERM; wb_dat_r SHALL be 0 in all other cycles and on err.
REQ-026 Write with err SHALL not modify any register.
REQ-027 wb_sel = 0 write SHALL ack and modify nothing.
REQ-028 xfer_cnt SHALL increment by 1 on each TERM cycle, wrapping 0xFFFF -> 0x0000.

Reset
REQ-029 On sys_rst high at a rising edge: state IDLE, wait counter 0, wb_ack 0, wb_err 0, wb_dat_r 0, xfer_cnt 0, all registers 0.
REQ-030 sys_rst SHALL take priority over every transition and write, including a cycle entering TERM.
REQ-031 A request in progress at reset SHALL be dropped; no termination SHALL follow reset for it.

Structure
REQ-032 Package wb_wait_slave_pkg SHALL hold the FSM state encoding, WAIT counter width (4), xfer_cnt width (16) and default parameter values.
REQ-033 Register array with byte-enable write SHALL be one sub-module wb_regbank (DATA_W, DEPTH params); FSM, counters and bus outputs in wb_wait_slave.

Verification
REQ-034 WAIT=0: write 0xA5A5_1234 sel=0xF adr=2, then read adr=2 -> ack 1 cycle after stb each, read data 0xA5A5_1234, xfer_cnt=2.
REQ-035 WAIT=3: single read adr=0 -> ack exactly 4 cycles after stb; cyc/stb held 3 cycles continuous -> ack every 5 cycles.
REQ-036 Byte enables: reg 1 = 0x1122_3344, write 0xFFFF_FFFF sel=0x5 -> read returns 0x11FF_33FF.
REQ-037 Out of range DEPTH=12: write adr=13 data 0xDEAD_BEEF -> wb_err 1 cycle, wb_ack 0, registers unchanged, wb_dat_r 0.
REQ-038 WAIT=3: stb dropped after 2 cycles -> no ack/err, no write, xfer_cnt unchanged; sys_rst asserted during WAIT -> all outputs 0, next request terminates normally.
REQ-039 Preload xfer_cnt to 0xFFFF via 65535 transfers, one more -> xfer_cnt = 0x0000.
